// File: rtl/c1_src_buf_ctrl.sv
// C1 source-buffer sequencer: loads one frame into five RAM copies, then sweeps 5-row columns.
// Optional build macro C1_CTRL_STALL_CNT_EN adds the saturating stall_cnt output.

module c1_src_buf_rd_lane #(
   parameter int unsigned OFS = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue,
   input  logic [31:0] base,
   output logic [31:0] addr
);
   always_ff @(posedge clk) begin
      if (rst)        addr <= '0;
      else if (issue) addr <= base + OFS;
   end
endmodule

module c1_src_buf_ctrl #(
   parameter int unsigned IMG_W = 32,
   parameter int unsigned IMG_H = 32,
   parameter int unsigned K     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       wr_data,
   output logic [31:0]       wr_addr,
   output logic              we,
   output logic [32*K-1:0]   rd_addr_5P,
   input  logic              col_ready,
   output logic              col_valid,
   output logic              col_first,
   output logic              col_last,
   output logic              busy,
   output logic              done
`ifdef C1_CTRL_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);
   localparam logic [31:0] NPIX     = 32'(IMG_W * IMG_H);
   localparam logic [31:0] ROW_LAST = 32'(IMG_H - K);
   localparam logic [31:0] COL_LAST = 32'(IMG_W - 1);
   localparam logic [31:0] W32      = 32'(IMG_W);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_t;

   state_t state, state_n;
   logic        accept, issue;
   logic [31:0] pix_cnt, row_cnt, col_cnt, row_base, base_c;
   logic [1:0]  vld_pipe, first_pipe, last_pipe;
   logic [K-1:0][31:0] lane_addr;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      issue   = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_n = S_LOAD;
         S_LOAD: begin
            accept = in_valid & in_ready;
            if (accept && pix_cnt == NPIX - 32'd1) state_n = S_SWEEP;
         end
         S_SWEEP: begin
            issue = col_ready;
            if (issue && row_cnt == ROW_LAST && col_cnt == COL_LAST) state_n = S_DONE;
         end
         // leave once the final column is on the output and nothing is left in flight
         S_DONE: if (vld_pipe[1] && !vld_pipe[0]) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt    <= '0;
         row_cnt    <= '0;
         col_cnt    <= '0;
         row_base   <= '0;
         in_ready   <= 1'b0;
         we         <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vld_pipe   <= '0;
         first_pipe <= '0;
         last_pipe  <= '0;
      end else begin
         in_ready <= (state_n == S_LOAD);
         busy     <= (state_n != S_IDLE);
         done     <= (state == S_DONE) && (state_n == S_IDLE);
         we       <= accept;
         if (accept) begin
            wr_addr <= pix_cnt;
            wr_data <= in_data;
            pix_cnt <= pix_cnt + 32'd1;
         end
         if (state == S_IDLE && start) begin
            pix_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            row_base <= '0;
         end else if (issue) begin
            if (col_cnt == COL_LAST) begin
               col_cnt  <= '0;
               row_cnt  <= row_cnt + 32'd1;
               row_base <= row_base + W32;
            end else begin
               col_cnt  <= col_cnt + 32'd1;
            end
         end
         // stage 0: address registered; stage 1: RAM data out
         vld_pipe   <= {vld_pipe[0], issue};
         first_pipe <= {first_pipe[0], issue && col_cnt == 32'd0};
         last_pipe  <= {last_pipe[0], issue && col_cnt == COL_LAST};
      end
   end

   assign col_valid = vld_pipe[1];
   assign col_first = first_pipe[1];
   assign col_last  = last_pipe[1];

   assign base_c = row_base + col_cnt;

   for (genvar p = 0; p < K; p++) begin : g_lane
      c1_src_buf_rd_lane #(.OFS(p * IMG_W)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .issue (issue),
         .base  (base_c),
         .addr  (lane_addr[p])
      );
   end

   assign rd_addr_5P = lane_addr;

`ifdef C1_CTRL_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (state == S_IDLE && start)
         stall_cnt <= '0;
      else if (((state == S_SWEEP && !col_ready) || (state == S_LOAD && !in_valid)) &&
               stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_c1_src_buf_ctrl.sv
// Scoreboard bench for c1_src_buf_ctrl with a behavioural five-port RAM model.
`timescale 1ns/1ps
module tb_c1_src_buf_ctrl;
   localparam int W = 32, H = 32, KK = 5;
   localparam int NPIX = W * H;
   localparam int NCOL = (H - KK + 1) * W;

   typedef struct packed { logic [31:0] a; logic [15:0] d; } wr_t;
   typedef struct packed {
      logic [KK-1:0][31:0] a;
      logic [KK-1:0][15:0] d;
      logic f;
      logic l;
   } col_t;

   logic clk, rst, start, in_valid, col_ready;
   logic [15:0] in_data;
   logic in_ready, we, col_valid, col_first, col_last, busy, done;
   logic [15:0] wr_data;
   logic [31:0] wr_addr;
   logic [KK-1:0][31:0] rd_addr_5P;
`ifdef C1_CTRL_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   c1_src_buf_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK)) dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .wr_data(wr_data), .wr_addr(wr_addr), .we(we),
      .rd_addr_5P(rd_addr_5P), .col_ready(col_ready), .col_valid(col_valid),
      .col_first(col_first), .col_last(col_last), .busy(busy), .done(done)
`ifdef C1_CTRL_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // five RAM copies with identical contents share one array; 1-cycle read latency
   logic [15:0] mem [0:NPIX-1];
   logic [KK-1:0][15:0] rd_data;
   always @(posedge clk) begin
      if (we) mem[wr_addr[9:0]] <= wr_data;
      for (int p = 0; p < KK; p++) rd_data[p] <= mem[rd_addr_5P[p][9:0]];
   end

   int tests = 0, fails = 0;
   wr_t  wq[$];
   col_t colq[$];
   int n_done, n_first, n_last, n_cols;
   logic prev_final;
   logic [KK-1:0][31:0] addr_prev, first_seen, last_seen;

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic col_t exp_col(input int idx, input logic [15:0] key);
      col_t e;
      int r, c;
      r = idx / W;
      c = idx % W;
      for (int p = 0; p < KK; p++) begin
         e.a[p] = 32'((r + p) * W + c);
         e.d[p] = 16'((r + p) * W + c) ^ key;
      end
      e.f = (c == 0);
      e.l = (c == W - 1);
      return e;
   endfunction

   // monitor: outputs are stable at negedge; rd_addr of the previous negedge is the issued address
   initial begin
      prev_final = 1'b0;
      addr_prev  = '0;
   end
   always @(negedge clk) begin
      if (we) begin
         if (wq.size() == 0) check("wr_unexpected", {128'd0, wr_addr}, 160'hFFFF_FFFF);
         else begin
            wr_t w;
            w = wq.pop_front();
            check("wr_addr", 160'(wr_addr), 160'(w.a));
            check("wr_data", 160'(wr_data), 160'(w.d));
         end
      end
      if (col_valid) begin
         if (colq.size() == 0) check("col_unexpected", 160'(n_cols), 160'(NCOL));
         else begin
            col_t e;
            e = colq.pop_front();
            check("col_addr", 160'(addr_prev), 160'(e.a));
            check("col_data", 160'(rd_data), 160'(e.d));
            check("col_flags", {158'd0, col_first, col_last}, {158'd0, e.f, e.l});
         end
         if (n_cols == 0) first_seen = addr_prev;
         last_seen = addr_prev;
         n_cols++;
         if (col_first) n_first++;
         if (col_last)  n_last++;
      end
      if (done) begin
         n_done++;
         check("done_after_last_col", 160'(prev_final), 160'(1));
      end
      prev_final = col_valid && (colq.size() == 0);
      addr_prev  = rd_addr_5P;
   end

   task automatic check_idle(input string nm);
      check({nm, "_in_ready"}, 160'(in_ready), 160'(0));
      check({nm, "_we"}, 160'(we), 160'(0));
      check({nm, "_wr"}, {112'd0, wr_addr, wr_data}, 160'(0));
      check({nm, "_rd_addr"}, 160'(rd_addr_5P), 160'(0));
      check({nm, "_col"}, {157'd0, col_valid, col_first, col_last}, 160'(0));
      check({nm, "_busy_done"}, {158'd0, busy, done}, 160'(0));
`ifdef C1_CTRL_STALL_CNT_EN
      check({nm, "_stall_cnt"}, 160'(stall_cnt), 160'(0));
`endif
   endtask

   task automatic run_load(input bit gaps, input int limit, input logic [15:0] key);
      int n = 0;
      int t = 0;
      int guard = 0;
      while (n < limit) begin
         in_valid = !(gaps && t[0]);
         in_data  = 16'(n) ^ key;
         if (in_valid && in_ready) begin
            wq.push_back('{a: 32'(n), d: 16'(n) ^ key});
            n++;
         end
         t++;
         guard++;
         @(negedge clk);
         if (guard > 4 * NPIX) begin
            check("load_timeout", 160'(n), 160'(limit));
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic run_sweep(input int stall_at, input int stall_len, input int start_at);
      int issued = 0;
      int sl = stall_len;
      col_t hold;
      hold = exp_col(stall_at - 1, 16'd0);
      while (issued < NCOL) begin
         start = (issued == start_at);
         if (issued == stall_at && sl > 0) begin
            check("stall_addr_hold", 160'(rd_addr_5P), 160'(hold.a));
            col_ready = 1'b0;
            sl--;
         end else begin
            col_ready = 1'b1;
            issued++;
         end
         @(negedge clk);
      end
      start     = 1'b0;
      col_ready = 1'b1;
   endtask

   task automatic run_frame(input bit gaps, input int stall_at, input int stall_len,
                            input int start_at, input logic [15:0] key);
      for (int i = 0; i < NCOL; i++) colq.push_back(exp_col(i, key));
      n_done = 0; n_first = 0; n_last = 0; n_cols = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("start_busy", 160'(busy), 160'(1));
      check("start_in_ready", 160'(in_ready), 160'(1));
      run_load(gaps, NPIX, key);
      run_sweep(stall_at, stall_len, start_at);
      for (int i = 0; i < 20 && n_done == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("done_count", 160'(n_done), 160'(1));
      check("col_count", 160'(n_cols), 160'(NCOL));
      check("first_count", 160'(n_first), 160'(28));
      check("last_count", 160'(n_last), 160'(28));
      check("wq_drained", 160'(wq.size()), 160'(0));
      check("colq_drained", 160'(colq.size()), 160'(0));
      check("idle_busy", 160'(busy), 160'(0));
      check("first_col_addr", 160'(first_seen),
            160'({32'd128, 32'd96, 32'd64, 32'd32, 32'd0}));
      check("last_col_addr", 160'(last_seen),
            160'({32'd1023, 32'd991, 32'd959, 32'd927, 32'd895}));
      colq.delete();
      wq.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; col_ready = 1'b1;
      n_done = 0; n_first = 0; n_last = 0; n_cols = 0;
      repeat (3) @(negedge clk);
      check_idle("por");
      rst = 1'b0;
      @(negedge clk);
      check_idle("por_rel");

      // reset in the middle of LOAD after 100 pixels
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      run_load(1'b0, 100, 16'h0000);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("midload_rst");
      rst = 1'b0;
      @(negedge clk);
      check_idle("midload_rel");
      check("midload_wq", 160'(wq.size()), 160'(0));

      // full frame, pixel = address, no gaps or stalls
      run_frame(1'b0, -1, 0, -1, 16'h0000);
      // in_valid toggling, distinct contents so stale RAM data cannot pass
      run_frame(1'b1, -1, 0, -1, 16'h5A00);
      // col_ready low for 10 cycles before column r=3,c=17
      run_frame(1'b0, 3 * W + 17, 10, -1, 16'h0C00);
`ifdef C1_CTRL_STALL_CNT_EN
      check("stall_cnt", 160'(stall_cnt), 160'(10));
`endif
      // start pulsed in the middle of the sweep must be ignored
      run_frame(1'b0, -1, 0, 200, 16'h3300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
